// File: rtl/fifo_pkg.sv
// Shared types and default parameters for the PITCH feed synchronous FIFO.
//  fifo_status_t : registered status flags presented by param_sync_fifo
//  DEF_*         : default parameter values for the FIFO and its RAM
package fifo_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_FWFT      = 0;
  localparam int unsigned DEF_AF_THRESH = 14;
  localparam int unsigned DEF_AE_THRESH = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Status after reset: nothing stored, so empty and almost_empty are set.
  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
//  clk   : write clock
//  we    : write enable
//  waddr : write address
//  wdata : write data
//  raddr : read address
//  rdata : read data (combinational from raddr)
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/empty levels,
// optional first-word-fall-through read, occupancy count and sticky errors.
//  clk, rst_n    : clock and synchronous active-low reset
//  wr_en/wr_data : write request and data
//  rd_en         : read request (pop in FWFT mode)
//  rd_data       : read data; rd_valid qualifies it
//  count         : occupancy 0..DEPTH
//  full, empty, almost_full, almost_empty : occupancy flags
//  overflow, underflow : sticky rejected-access flags, cleared by clr_err
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned FWFT      = DEF_FWFT,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  fifo_status_t      status_q, status_nxt;
  logic              rd_acc, wr_acc;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_data_q, rd_data_nxt;
  logic              rd_valid_q, rd_valid_nxt;

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Accept decisions, pointer/count advance and next flags.
  always_comb begin
    rd_acc    = rd_en & ~status_q.empty;
    wr_acc    = wr_en & (~status_q.full | rd_acc);
    wptr_nxt  = wptr + PTR_W'(wr_acc);
    rptr_nxt  = rptr + PTR_W'(rd_acc);
    count_nxt = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    status_nxt              = status_q;
    status_nxt.full         = (count_nxt == CNT_W'(DEPTH));
    status_nxt.empty        = (count_nxt == '0);
    status_nxt.almost_full  = (count_nxt >= CNT_W'(AF_THRESH));
    status_nxt.almost_empty = (count_nxt <= CNT_W'(AE_THRESH));
    // An error event in the same cycle as clr_err keeps the flag set.
    status_nxt.overflow     = (wr_en & ~wr_acc) | (status_q.overflow  & ~clr_err);
    status_nxt.underflow    = (rd_en & ~rd_acc) | (status_q.underflow & ~clr_err);
  end

  // Read path. FWFT pre-loads the next head word into the output register,
  // bypassing the RAM when the head is the word being written this cycle.
  always_comb begin
    ram_raddr    = rptr[ADDR_W-1:0];
    rd_data_nxt  = rd_data_q;
    rd_valid_nxt = rd_acc;
    if (FWFT != 0) begin
      ram_raddr    = rptr_nxt[ADDR_W-1:0];
      rd_valid_nxt = (count_nxt != '0);
      if (count_q == CNT_W'(rd_acc)) begin
        rd_data_nxt = wr_data;
      end else begin
        rd_data_nxt = ram_rdata;
      end
    end else if (rd_acc) begin
      rd_data_nxt = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      status_q   <= STATUS_RST;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      count_q    <= count_nxt;
      status_q   <= status_nxt;
      rd_data_q  <= rd_data_nxt;
      rd_valid_q <= rd_valid_nxt;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: one registered-read and one FWFT instance share
// stimulus; a queue-based reference model feeds a scoreboard monitor.
module tb_param_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid;
  logic [CW-1:0] a_count, b_count;
  logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf),
    .underflow(a_unf), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf),
    .underflow(b_unf), .clr_err(clr_err)
  );

  // Reference model state.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] m_hold0;
  logic          m_ovf, m_unf;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is a queue bounded at DEPTH entries.
  always @(posedge clk) begin : model
    bit            racc, wacc;
    logic [DW-1:0] v;
    if (!rst_n) begin
      model_q.delete();
      exp0.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_hold0 = '0;
    end else begin
      racc = rd_en && (model_q.size() > 0);
      wacc = wr_en && ((model_q.size() < DEPTH) || racc);
      if (racc) begin
        v = model_q.pop_front();
        exp0.push_back(v);
        m_hold0 = v;
      end
      if (wacc) model_q.push_back(wr_data);
      if (wr_en && !wacc) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (rd_en && !racc) m_unf = 1'b1;
      else if (clr_err)   m_unf = 1'b0;
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    int         occ;
    logic [5:0] exp_st;
    if (mon_en) begin
      occ    = model_q.size();
      exp_st = {occ == DEPTH, occ == 0, occ >= AF, occ <= AE, m_ovf, m_unf};
      check("count", 32'(a_count), 32'(occ));
      check("count_fwft", 32'(b_count), 32'(occ));
      check("status", 32'({a_full, a_empty, a_af, a_ae, a_ovf, a_unf}), 32'(exp_st));
      check("status_fwft", 32'({b_full, b_empty, b_af, b_ae, b_ovf, b_unf}), 32'(exp_st));
      if (a_rd_valid) begin
        if (exp0.size() == 0) check("rd_valid_spurious", 32'(a_rd_valid), 32'(0));
        else                  check("rd_data", 32'(a_rd_data), 32'(exp0.pop_front()));
      end else begin
        check("rd_data_hold", 32'(a_rd_data), 32'(m_hold0));
      end
      check("rd_latency", 32'(exp0.size()), 32'(0));
      exp0.delete();
      check("fwft_valid", 32'(b_rd_valid), 32'(occ > 0));
      if (occ > 0) check("fwft_head", 32'(b_rd_data), 32'(model_q[0]));
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int nw, nr, wp, rp;
    bit w, r;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    cyc(0, 8'h00, 0, 1);
    // Read and write together at full.
    cyc(1, 8'h64, 1, 0);
    // Drain, one rejected read, clear.
    repeat (16) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);
    // Read and write together at empty, then read the word back.
    cyc(1, 8'h55, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);

    // Stream 0..39 with occupancy held within 0..5.
    nw = 0; nr = 0;
    for (int k = 0; k < 2000 && nr < 40; k++) begin
      w = (nw < 40) && (model_q.size() < 5) && ($urandom_range(0, 1) == 1);
      r = (model_q.size() > 0) && ($urandom_range(0, 1) == 1);
      cyc(w, 8'(nw), r, 0);
      if (w) nw++;
      if (r) nr++;
    end
    check("stream_done", 32'(nr), 32'(40));

    // Single word into empty FIFO, left unread for two cycles, then popped.
    cyc(1, 8'hA5, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // Reset with data stored, then reuse.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // Random traffic with fill-biased, drain-biased and balanced segments.
    for (int seg = 0; seg < 6; seg++) begin
      wp = (seg % 3 == 0) ? 75 : (seg % 3 == 1) ? 25 : 50;
      rp = 100 - wp;
      for (int k = 0; k < 400; k++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 15) == 0);
      end
    end

    rst_n = 1'b1;
    repeat (20) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);
    check("final_empty", 32'(a_empty), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
